// File: rtl/spi_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_shift_engine
//
// Serial data engine that sits behind the SPI clock/chip-select former. It
// takes a parallel word over a valid/ready handshake, requests a transfer from
// the former through `work`, then follows the former's `dclk`/`cs` to shift the
// word out on `mosi` while capturing `miso`. A completed frame returns the
// received word with a one-cycle `rx_valid`; a frame cut short by `cs` rising
// early returns a one-cycle `frame_err` instead.
//
// Mode: data is launched on falling `dclk` and sampled on rising `dclk`;
// `dclk` idles high and `cs` is active low.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   tx_data    in   [WIDTH] word to transmit
//   tx_valid   in   tx_data valid
//   tx_ready   out  engine can accept a word (IDLE only)
//   work       out  transfer request to the clock/cs former
//   dclk       in   serial clock from the former (asynchronous to clk)
//   cs         in   chip select from the former, active low (asynchronous)
//   miso       in   serial data in (asynchronous)
//   mosi       out  serial data out, idles high
//   rx_data    out  [WIDTH] last completely received word
//   rx_valid   out  one-cycle pulse, rx_data updated
//   frame_err  out  one-cycle pulse, frame aborted by early cs release
//   busy       out  high in any state other than IDLE
//
// Handshake: a word is accepted on exactly the rising clk edge where
// tx_valid && tx_ready are both high; tx_data is captured on that edge only.
// tx_valid is ignored whenever tx_ready is low, and the producer may change
// tx_data freely after acceptance.
// -----------------------------------------------------------------------------
module spi_shift_engine #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             work,
  input  logic             dclk,
  input  logic             cs,
  input  logic             miso,
  output logic             mosi,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q;

  // Input synchronisers; the extra *_d_q copy gives the edge detectors.
  logic             dclk_s1_q, dclk_s2_q, dclk_d_q;
  logic             cs_s1_q, cs_s2_q, cs_d_q;
  logic             miso_s1_q, miso_s2_q;

  logic [WIDTH-1:0] tx_sr_q;
  logic [WIDTH-1:0] rx_sr_q;
  logic [WIDTH-1:0] rx_data_q;
  logic [CW-1:0]    cnt_q;
  logic             tx_ready_q;
  logic             work_q;
  logic             mosi_q;
  logic             rx_valid_q;
  logic             frame_err_q;

  logic             dclk_rise;
  logic             dclk_fall;
  logic             cs_rise;
  logic [WIDTH-1:0] tx_sr_d;
  logic [WIDTH-1:0] rx_sr_d;
  logic             tx_first_bit;
  logic             tx_next_bit;

  // ---------------------------------------------------------------------------
  // Synchronisers. Reset to the idle levels of the former's outputs so that
  // leaving reset never looks like an edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dclk_s1_q <= 1'b1;
      dclk_s2_q <= 1'b1;
      dclk_d_q  <= 1'b1;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_d_q    <= 1'b1;
      miso_s1_q <= 1'b1;
      miso_s2_q <= 1'b1;
    end else begin
      dclk_s1_q <= dclk;
      dclk_s2_q <= dclk_s1_q;
      dclk_d_q  <= dclk_s2_q;
      cs_s1_q   <= cs;
      cs_s2_q   <= cs_s1_q;
      cs_d_q    <= cs_s2_q;
      miso_s1_q <= miso;
      miso_s2_q <= miso_s1_q;
    end
  end

  assign dclk_rise = dclk_s2_q & ~dclk_d_q;
  assign dclk_fall = ~dclk_s2_q & dclk_d_q;
  assign cs_rise   = cs_s2_q & ~cs_d_q;

  // ---------------------------------------------------------------------------
  // Shift datapath for the selected bit order. The TX register rotates rather
  // than shifting in a constant so every bit stays live; only the bit that
  // lands at the output end after a shift is ever presented on mosi.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    tx_first_bit = 1'b1;
    tx_next_bit  = 1'b1;
    if (MSB_FIRST) begin
      tx_sr_d      = {tx_sr_q[WIDTH-2:0], tx_sr_q[WIDTH-1]};
      tx_next_bit  = tx_sr_q[WIDTH-2];
      tx_first_bit = tx_data[WIDTH-1];
      rx_sr_d      = {rx_sr_q[WIDTH-2:0], miso_s2_q};
    end else begin
      tx_sr_d      = {tx_sr_q[0], tx_sr_q[WIDTH-1:1]};
      tx_next_bit  = tx_sr_q[1];
      tx_first_bit = tx_data[0];
      rx_sr_d      = {miso_s2_q, rx_sr_q[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      cnt_q       <= '0;
      tx_ready_q  <= 1'b0;
      work_q      <= 1'b0;
      mosi_q      <= 1'b1;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (tx_valid && tx_ready_q) begin
            tx_sr_q    <= tx_data;
            mosi_q     <= tx_first_bit;
            cnt_q      <= '0;
            work_q     <= 1'b1;
            tx_ready_q <= 1'b0;
            state_q    <= ST_REQ;
          end else begin
            // tx_ready lags entry to IDLE by one cycle, which guarantees at
            // least one idle clk between rx_valid and the next acceptance.
            tx_ready_q <= 1'b1;
          end
        end

        ST_REQ: begin
          if (!cs_s2_q) begin
            state_q <= ST_XFER;
          end
        end

        ST_XFER: begin
          // The counter is always below WIDTH here because the final rise
          // moves straight to DONE, so any cs rise in XFER is an abort.
          if (cs_rise) begin
            frame_err_q <= 1'b1;
            work_q      <= 1'b0;
            mosi_q      <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (dclk_rise) begin
            rx_sr_q <= rx_sr_d;
            cnt_q   <= cnt_q + CNT_ONE;
            if (cnt_q == LAST_BIT) begin
              work_q  <= 1'b0;
              mosi_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end else if (dclk_fall && (cnt_q != CNT_ZERO)) begin
            // The leading fall (before any rise) launches nothing: the first
            // bit has been on mosi since acceptance.
            tx_sr_q <= tx_sr_d;
            mosi_q  <= tx_next_bit;
          end
        end

        ST_DONE: begin
          if (cs_s2_q) begin
            rx_data_q  <= rx_sr_q;
            rx_valid_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready  = tx_ready_q;
  assign work      = work_q;
  assign mosi      = mosi_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_shift_engine
//
// Two engines share one clock/cs former model: dut_m shifts MSB first, dut_l
// LSB first. `sel` chooses which engine's `work` the former answers. The former
// also acts as the SPI slave, driving miso on falling dclk and checking the
// mosi bit just before each rising dclk. Expected bit streams and received
// words come from a bit-index reference model applied to the queued words.
// -----------------------------------------------------------------------------
module tb_spi_shift_engine;

  localparam int W    = 16;
  localparam int HALF = 5;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] tx_data;
  logic         tx_valid_m, tx_valid_l;
  logic         dclk, cs, miso;

  logic         tx_ready_m, work_m, mosi_m, rx_valid_m, frame_err_m, busy_m;
  logic [W-1:0] rx_data_m;
  logic         tx_ready_l, work_l, mosi_l, rx_valid_l, frame_err_l, busy_l;
  logic [W-1:0] rx_data_l;

  spi_shift_engine #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid_m),
    .tx_ready(tx_ready_m), .work(work_m), .dclk(dclk), .cs(cs), .miso(miso),
    .mosi(mosi_m), .rx_data(rx_data_m), .rx_valid(rx_valid_m),
    .frame_err(frame_err_m), .busy(busy_m)
  );

  spi_shift_engine #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid_l),
    .tx_ready(tx_ready_l), .work(work_l), .dclk(dclk), .cs(cs), .miso(miso),
    .mosi(mosi_l), .rx_data(rx_data_l), .rx_valid(rx_valid_l),
    .frame_err(frame_err_l), .busy(busy_l)
  );

  // ---------------------------------------------------------------- checking
  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: which bit of a word travels in serial slot i.
  function automatic logic bit_at(input logic [W-1:0] w, input int i, input bit msb);
    return msb ? w[W-1-i] : w[i];
  endfunction

  // Per-frame plan consumed by the former, and expected received words.
  logic [W-1:0] tx_q[$];
  logic [W-1:0] sl_q[$];
  int           stop_q[$];
  bit           ab_q[$];
  logic [W-1:0] exp_m_q[$];
  logic [W-1:0] exp_l_q[$];

  bit           sel = 1'b0;

  // ---------------------------------------------------------------- former + slave model
  logic [W-1:0] fm_tw, fm_sw;
  int           fm_stop;
  bit           fm_ab, fm_msb;
  int           fm_rises = 0;
  int           fm_done  = 0;

  initial begin : former
    dclk = 1'b1;
    cs   = 1'b1;
    miso = 1'b1;
    forever begin
      @(negedge clk);
      if ((sel ? work_l : work_m) === 1'b1 && tx_q.size() > 0) begin
        fm_tw    = tx_q.pop_front();
        fm_sw    = sl_q.pop_front();
        fm_stop  = stop_q.pop_front();
        fm_ab    = ab_q.pop_front();
        fm_msb   = !sel;
        fm_rises = 0;
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < fm_stop; i++) begin
          dclk = 1'b0;
          miso = bit_at(fm_sw, i, fm_msb);
          repeat (HALF) @(negedge clk);
          check("mosi_bit", sel ? mosi_l : mosi_m, bit_at(fm_tw, i, fm_msb));
          check("work_before_rise", sel ? work_l : work_m, 1);
          dclk = 1'b1;
          fm_rises++;
          repeat (HALF) @(negedge clk);
        end
        if (fm_ab) begin
          cs = 1'b1;
        end else if (fm_stop == W) begin
          check("work_after_last_rise", sel ? work_l : work_m, 0);
          check("mosi_idle_after_frame", sel ? mosi_l : mosi_m, 1);
        end
        for (int n = 0; n < 60 && (sel ? work_l : work_m) !== 1'b0; n++) @(negedge clk);
        check("work_low_end_of_frame", sel ? work_l : work_m, 0);
        repeat (2) @(negedge clk);
        cs   = 1'b1;
        miso = 1'b1;
        repeat (6) @(negedge clk);
        fm_done++;
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard monitor
  int rxv_m = 0, rxv_l = 0, ferr_m = 0, ferr_l = 0, viol = 0;

  always @(negedge clk) begin
    if (busy_m === 1'b1 && tx_ready_m === 1'b1) viol++;
    if (busy_l === 1'b1 && tx_ready_l === 1'b1) viol++;
    if (frame_err_m === 1'b1) ferr_m++;
    if (frame_err_l === 1'b1) ferr_l++;
    if (rx_valid_m === 1'b1) begin
      rxv_m++;
      check("rx_valid_gap_ready_m", tx_ready_m, 0);
      check("rx_expected_pending_m", exp_m_q.size() > 0, 1);
      if (exp_m_q.size() > 0) check("rx_data_m", rx_data_m, exp_m_q.pop_front());
    end
    if (rx_valid_l === 1'b1) begin
      rxv_l++;
      check("rx_valid_gap_ready_l", tx_ready_l, 0);
      check("rx_expected_pending_l", exp_l_q.size() > 0, 1);
      if (exp_l_q.size() > 0) check("rx_data_l", rx_data_l, exp_l_q.pop_front());
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic queue_frame(input logic [W-1:0] tw, input logic [W-1:0] sw,
                             input int stop, input bit ab, input bit lsb);
    tx_q.push_back(tw);
    sl_q.push_back(sw);
    stop_q.push_back(stop);
    ab_q.push_back(ab);
    if (stop == W && !ab) begin
      if (lsb) exp_l_q.push_back(sw);
      else     exp_m_q.push_back(sw);
    end
  endtask

  task automatic wait_ready(input bit lsb);
    for (int n = 0; n < 400 && (lsb ? tx_ready_l : tx_ready_m) !== 1'b1; n++) @(negedge clk);
    check("ready_before_send", lsb ? tx_ready_l : tx_ready_m, 1);
  endtask

  task automatic send(input bit lsb, input logic [W-1:0] w);
    wait_ready(lsb);
    tx_data = w;
    if (lsb) tx_valid_l = 1'b1;
    else     tx_valid_m = 1'b1;
    @(negedge clk);
    check("accepted_ready_low", lsb ? tx_ready_l : tx_ready_m, 0);
    tx_valid_m = 1'b0;
    tx_valid_l = 1'b0;
    tx_data    = W'($urandom);
  endtask

  task automatic wait_frames(input int target);
    for (int n = 0; n < 3000 && fm_done < target; n++) @(negedge clk);
    check("frame_completed", fm_done >= target, 1);
    repeat (4) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- directed sequence
  logic [W-1:0] tw, sw, sw2, last_m;
  int           r0, f0, rl0, fl0, d0;
  bit           lsb;

  initial begin : main
    rst        = 1'b1;
    tx_valid_m = 1'b0;
    tx_valid_l = 1'b0;
    tx_data    = '0;

    // Reset held three cycles with random handshake inputs.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("ready_in_rst_m", tx_ready_m, 0);
      check("ready_in_rst_l", tx_ready_l, 0);
      tx_valid_m = 1'($urandom_range(0, 1));
      tx_valid_l = 1'($urandom_range(0, 1));
      tx_data    = W'($urandom);
    end
    @(negedge clk);
    check("ready_last_rst_cycle", tx_ready_m, 0);
    rst        = 1'b0;
    tx_valid_m = 1'b0;
    tx_valid_l = 1'b0;
    @(negedge clk);
    check("rst_tx_ready", tx_ready_m, 1);
    check("rst_tx_ready_l", tx_ready_l, 1);
    check("rst_work", work_m, 0);
    check("rst_mosi", mosi_m, 1);
    check("rst_busy", busy_m, 0);
    check("rst_rx_data", rx_data_m, 0);
    check("rst_rx_valid", rx_valid_m, 0);
    check("rst_frame_err", frame_err_m, 0);

    // Single MSB-first frame with the documented words.
    sel = 1'b0;
    queue_frame(16'hA5C3, 16'h3C5A, W, 1'b0, 1'b0);
    r0 = rxv_m; d0 = fm_done;
    send(1'b0, 16'hA5C3);
    check("busy_during_frame", busy_m, 1);
    wait_frames(d0 + 1);
    check("single_rx_valid_count", rxv_m - r0, 1);
    check("single_rx_data", rx_data_m, 16'h3C5A);

    // LSB-first frame.
    sel = 1'b1;
    queue_frame(16'h0001, 16'h8000, W, 1'b0, 1'b1);
    rl0 = rxv_l; d0 = fm_done;
    send(1'b1, 16'h0001);
    wait_frames(d0 + 1);
    check("lsb_rx_valid_count", rxv_l - rl0, 1);
    check("lsb_rx_data", rx_data_l, 16'h8000);

    // Randomised frames on both bit orders.
    for (int k = 0; k < 4; k++) begin
      lsb = k[0];
      sel = lsb;
      tw  = W'($urandom);
      sw  = W'($urandom);
      queue_frame(tw, sw, W, 1'b0, lsb);
      d0 = fm_done;
      send(lsb, tw);
      wait_frames(d0 + 1);
      check("rand_rx_data", lsb ? rx_data_l : rx_data_m, sw);
    end

    // Back-to-back: tx_valid held high across two words.
    sel = 1'b0;
    sw  = W'($urandom);
    sw2 = W'($urandom);
    queue_frame(16'h1111, sw, W, 1'b0, 1'b0);
    queue_frame(16'h2222, sw2, W, 1'b0, 1'b0);
    r0 = rxv_m; d0 = fm_done;
    wait_ready(1'b0);
    tx_data    = 16'h1111;
    tx_valid_m = 1'b1;
    @(negedge clk);
    check("b2b_first_accepted", tx_ready_m, 0);
    tx_data = 16'h2222;
    for (int n = 0; n < 2000 && tx_ready_m !== 1'b1; n++) @(negedge clk);
    check("b2b_ready_between_frames", tx_ready_m, 1);
    check("b2b_one_rx_before_second", rxv_m - r0, 1);
    @(negedge clk);
    check("b2b_second_accepted", tx_ready_m, 0);
    tx_valid_m = 1'b0;
    wait_frames(d0 + 2);
    check("b2b_rx_valid_count", rxv_m - r0, 2);
    check("b2b_rx_data", rx_data_m, sw2);
    last_m = sw2;

    // Abort: cs released after 7 rising edges.
    sel = 1'b0;
    queue_frame(W'($urandom), W'($urandom), 7, 1'b1, 1'b0);
    r0 = rxv_m; f0 = ferr_m; d0 = fm_done;
    send(1'b0, tx_q[0]);
    for (int n = 0; n < 2000 && frame_err_m !== 1'b1; n++) @(negedge clk);
    check("abort_frame_err", frame_err_m, 1);
    check("abort_rx_data_kept", rx_data_m, last_m);
    check("abort_work", work_m, 0);
    check("abort_mosi", mosi_m, 1);
    check("abort_ready_same_cycle", tx_ready_m, 0);
    @(negedge clk);
    check("abort_ready_next_cycle", tx_ready_m, 1);
    check("abort_frame_err_one_cycle", frame_err_m, 0);
    wait_frames(d0 + 1);
    check("abort_no_rx_valid", rxv_m - r0, 0);
    check("abort_frame_err_count", ferr_m - f0, 1);

    // Reset mid-frame after 10 bits.
    sel = 1'b0;
    queue_frame(W'($urandom), W'($urandom), 10, 1'b0, 1'b0);
    r0 = rxv_m; f0 = ferr_m; rl0 = rxv_l; fl0 = ferr_l; d0 = fm_done;
    send(1'b0, tx_q[0]);
    for (int n = 0; n < 2000 && fm_rises < 10; n++) @(negedge clk);
    check("midrst_reached_bit10", fm_rises, 10);
    check("midrst_busy_before", busy_m, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_work", work_m, 0);
    check("midrst_mosi", mosi_m, 1);
    check("midrst_busy", busy_m, 0);
    check("midrst_rx_data", rx_data_m, 0);
    check("midrst_ready_in_rst", tx_ready_m, 0);
    @(negedge clk);
    check("midrst_ready_after", tx_ready_m, 1);
    wait_frames(d0 + 1);
    repeat (10) @(negedge clk);
    check("midrst_no_rx_valid", rxv_m - r0, 0);
    check("midrst_no_frame_err", ferr_m - f0, 0);
    check("midrst_no_rx_valid_l", rxv_l - rl0, 0);
    check("midrst_no_frame_err_l", ferr_l - fl0, 0);

    // Full frame after the reset.
    sw = W'($urandom);
    queue_frame(16'hFFFF, sw, W, 1'b0, 1'b0);
    r0 = rxv_m; d0 = fm_done;
    send(1'b0, 16'hFFFF);
    wait_frames(d0 + 1);
    check("post_rst_rx_valid_count", rxv_m - r0, 1);
    check("post_rst_rx_data", rx_data_m, sw);

    // Final scoreboard state.
    check("ready_low_while_busy", viol, 0);
    check("exp_m_queue_drained", exp_m_q.size(), 0);
    check("exp_l_queue_drained", exp_l_q.size(), 0);
    check("plan_queue_drained", tx_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
